me_pixel_feeder: RTL

//  Source end of the PE array pixel interface for the full-search motion estimator.
//  On start it reads the NxN template block from template RAM and streams it on en_tb/pel_tb.
//  It then reads the (N+2R)x(N+2R) search window from search RAM and streams it on en_sw/pel_sw.

---
 rtl/me_pixel_feeder_if.sv | 47 ++++
 rtl/me_pixel_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/me_pixel_feeder_if.sv
// Pixel feeder bus bundle: control handshake, template/search RAM read
// ports and the two pixel streams towards the PE array.
// The feeder itself uses the master view; the environment uses the slave view.
interface me_pixel_feeder_if #(
  parameter int TB_AW = 8,
  parameter int SW_AW = 10
);

  // Block-level control
  logic             start;
  logic             hold;
  logic             busy;
  logic             done;

  // Template RAM read port
  logic             tb_re;
  logic [TB_AW-1:0] tb_addr;
  logic [7:0]       tb_rdata;

  // Search RAM read port
  logic             sw_re;
  logic [SW_AW-1:0] sw_addr;
  logic [7:0]       sw_rdata;

  // Pixel streams towards the PE array
  logic             en_tb;
  logic [7:0]       pel_tb;
  logic             tb_last;
  logic             en_sw;
  logic [7:0]       pel_sw;
  logic             sw_last;

  modport master (
    input  start, hold, tb_rdata, sw_rdata,
    output busy, done,
    output tb_re, tb_addr, sw_re, sw_addr,
    output en_tb, pel_tb, tb_last, en_sw, pel_sw, sw_last
  );

  modport slave (
    output start, hold, tb_rdata, sw_rdata,
    input  busy, done,
    input  tb_re, tb_addr, sw_re, sw_addr,
    input  en_tb, pel_tb, tb_last, en_sw, pel_sw, sw_last
  );

endinterface

// File: rtl/me_pixel_feeder.sv
// Source end of the PE array pixel interface for the full-search motion
// estimator. One start reads the NxN template block in raster order and
// streams it, then reads the (N+2R)x(N+2R) search window and streams it,
// one pixel per cycle with a fixed two-cycle read-to-output latency.
module me_pixel_feeder #(
  parameter int N     = 16,
  parameter int R     = 8,
  parameter int TB_AW = 8,
  parameter int SW_AW = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  me_pixel_feeder_if.master     pix
);

  localparam int SW_W   = N + 2 * R;
  localparam int TB_CNT = N * N;
  localparam int SW_CNT = SW_W * SW_W;

  localparam logic [TB_AW-1:0] TB_END = TB_AW'(TB_CNT - 1);
  localparam logic [SW_AW-1:0] SW_END = SW_AW'(SW_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TB    = 2'd1,
    ST_SW    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q;
  logic [TB_AW-1:0] tbIdx_q;
  logic [SW_AW-1:0] swIdx_q;
  logic             busy_q;
  logic             done_q;

  // Read-issue strobes for the current cycle
  logic             tbRe_d;
  logic             swRe_d;
  logic             tbReLast_d;
  logic             swReLast_d;

  // Stage 1: a read was issued last cycle, so RAM data is valid now
  logic             rdTb_q;
  logic             rdSw_q;
  logic             rdTbLast_q;
  logic             rdSwLast_q;

  // Stage 2: registered pixel streams
  logic             enTb_q;
  logic [7:0]       pelTb_q;
  logic             tbLast_q;
  logic             enSw_q;
  logic [7:0]       pelSw_q;
  logic             swLast_q;

  // Reads are issued straight from the state so that hold stalls the RAM in the same cycle
  always_comb begin
    tbRe_d     = (state_q == ST_TB) && !pix.hold;
    swRe_d     = (state_q == ST_SW) && !pix.hold;
    tbReLast_d = tbRe_d && (tbIdx_q == TB_END);
    swReLast_d = swRe_d && (swIdx_q == SW_END);
  end

  // Block sequencer: walks template then search indices, then waits for the pipe to empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tbIdx_q <= '0;
      swIdx_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pix.start) begin
            state_q <= ST_TB;
            busy_q  <= 1'b1;
            tbIdx_q <= '0;
            swIdx_q <= '0;
          end
        end
        ST_TB: begin
          if (tbRe_d) begin
            if (tbReLast_d) begin
              state_q <= ST_SW;
            end else begin
              tbIdx_q <= tbIdx_q + TB_AW'(1);
            end
          end
        end
        ST_SW: begin
          if (swRe_d) begin
            if (swReLast_d) begin
              state_q <= ST_DRAIN;
            end else begin
              swIdx_q <= swIdx_q + SW_AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (done_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (!rdTb_q && !rdSw_q) begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Track which reads are in flight so their data is captured one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdTb_q     <= 1'b0;
      rdSw_q     <= 1'b0;
      rdTbLast_q <= 1'b0;
      rdSwLast_q <= 1'b0;
    end else begin
      rdTb_q     <= tbRe_d;
      rdSw_q     <= swRe_d;
      rdTbLast_q <= tbReLast_d;
      rdSwLast_q <= swReLast_d;
    end
  end

  // Register RAM data onto the PE streams; pixels keep their last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enTb_q   <= 1'b0;
      pelTb_q  <= '0;
      tbLast_q <= 1'b0;
      enSw_q   <= 1'b0;
      pelSw_q  <= '0;
      swLast_q <= 1'b0;
    end else begin
      enTb_q   <= rdTb_q;
      tbLast_q <= rdTbLast_q;
      enSw_q   <= rdSw_q;
      swLast_q <= rdSwLast_q;
      if (rdTb_q) begin
        pelTb_q <= pix.tb_rdata;
      end
      if (rdSw_q) begin
        pelSw_q <= pix.sw_rdata;
      end
    end
  end

  assign pix.busy    = busy_q;
  assign pix.done    = done_q;
  assign pix.tb_re   = tbRe_d;
  assign pix.tb_addr = tbIdx_q;
  assign pix.sw_re   = swRe_d;
  assign pix.sw_addr = swIdx_q;
  assign pix.en_tb   = enTb_q;
  assign pix.pel_tb  = pelTb_q;
  assign pix.tb_last = tbLast_q;
  assign pix.en_sw   = enSw_q;
  assign pix.pel_sw  = pelSw_q;
  assign pix.sw_last = swLast_q;

endmodule
